fifo_wr_arbiter: RTL



---
 rtl/fifo_wr_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ write-domain requesters.
// Latency: one IDLE cycle to select an owner, then one word per cycle combinationally to wr_en/data_in.
// Backpressure: full stalls the owner (req_ready=0, wr_en=0, burst count held); grant ends after MAX_BURST words.
//
// Ports:
//   clk, rst        write-domain clock, synchronous active-high reset
//   req_valid/data  per-requester word valid and data (slice i at [i*DATA_WIDTH +: DATA_WIDTH])
//   req_ready       per-requester accept, one-hot or zero
//   full            FIFO full flag; wr_en/data_in drive the FIFO write port
//   grant_id, busy  current/last owner index; high while an owner holds the grant
//   stat_wr_count   per-requester saturating 16-bit write counters, present only when
//                   FIFO_WR_ARB_STATS_EN is defined
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic                            full,
   output logic                            wr_en,
   output logic [DATA_WIDTH-1:0]           data_in,
   output logic [$clog2(NUM_REQ)-1:0]      grant_id,
   output logic                            busy
`ifdef FIFO_WR_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]           stat_wr_count
`endif
);

   localparam int IW = $clog2(NUM_REQ);
   localparam logic [7:0]    LAST_BEAT = 8'(MAX_BURST - 1);
   localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);
   localparam logic [IW:0]   NUM_REQ_W = (IW+1)'(NUM_REQ);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t        state, state_nxt;
   logic [IW-1:0] rr_ptr, rr_ptr_nxt;
   logic [IW-1:0] grant_nxt;
   logic [7:0]    burst_cnt, burst_nxt;
   logic [IW-1:0] sel_idx, owner_inc;
   logic [IW:0]   scan_pos;
   logic          sel_found;
   logic          owner_valid;
   logic          xfer;

   // Scan from rr_ptr upwards (mod NUM_REQ). Walking the offsets from the far end
   // down to 0 lets the closest valid requester overwrite any later one.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      scan_pos  = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         scan_pos = {1'b0, rr_ptr} + (IW+1)'(k);
         if (scan_pos >= NUM_REQ_W) scan_pos = scan_pos - NUM_REQ_W;
         if (req_valid[scan_pos[IW-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = scan_pos[IW-1:0];
         end
      end
   end

   assign owner_valid = req_valid[grant_id];
   assign owner_inc   = (grant_id == LAST_IDX) ? '0 : grant_id + IW'(1);
   assign data_in     = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
   assign busy        = (state == GRANT);

   always_comb begin
      state_nxt  = state;
      rr_ptr_nxt = rr_ptr;
      grant_nxt  = grant_id;
      burst_nxt  = burst_cnt;
      xfer       = 1'b0;
      wr_en      = 1'b0;
      req_ready  = '0;
      case (state)
         IDLE: begin
            if (sel_found) begin
               grant_nxt = sel_idx;
               burst_nxt = '0;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            // The state register can still read GRANT during the reset cycle,
            // so the handshake is gated by rst directly.
            if (!rst) begin
               req_ready[grant_id] = ~full;
               xfer                = owner_valid & ~full;
            end
            wr_en = xfer;
            if (xfer) burst_nxt = burst_cnt + 8'd1;
            if ((xfer && burst_cnt == LAST_BEAT) || !owner_valid) begin
               state_nxt  = IDLE;
               rr_ptr_nxt = owner_inc;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         burst_cnt <= '0;
         grant_id  <= '0;
      end else begin
         state     <= state_nxt;
         rr_ptr    <= rr_ptr_nxt;
         burst_cnt <= burst_nxt;
         grant_id  <= grant_nxt;
      end
   end

`ifdef FIFO_WR_ARB_STATS_EN
   logic [15:0] wr_count [NUM_REQ];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++) wr_count[i] <= '0;
      end else if (xfer && wr_count[grant_id] != 16'hFFFF) begin
         wr_count[grant_id] <= wr_count[grant_id] + 16'd1;
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
      assign stat_wr_count[g*16 +: 16] = wr_count[g];
   end
`endif

endmodule
